gbar_arbiter: RTL and testbench

GBAR_ARBITER -- requirements
Module: gbar_arbiter

---
 rtl/gbar_arbiter.sv | 108 ++++++++++
 tb/tb_gbar_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/gbar_arbiter.sv
// Global barrier arbiter: cores post arrivals against barrier IDs. Arrivals are accepted one per cycle
// in round-robin order, and a release is broadcast once every participating core has arrived.
module gbar_arbiter #(
    parameter  int unsigned NUM_CORES    = 4,
    parameter  int unsigned NUM_BARRIERS = 4,
    localparam int unsigned NC_WIDTH     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
    localparam int unsigned NB_WIDTH     = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CORES-1:0]          req_valid,
    input  logic [NUM_CORES*NB_WIDTH-1:0] req_id,
    input  logic [NUM_CORES*NC_WIDTH-1:0] req_size_m1,
    output logic [NUM_CORES-1:0]          req_ready,
    output logic                          rsp_valid,
    output logic [NB_WIDTH-1:0]           rsp_id,
    output logic                          err_valid
);

    logic [NUM_CORES-1:0] mask  [NUM_BARRIERS];
    logic [NC_WIDTH-1:0]  count [NUM_BARRIERS];
    logic [NC_WIDTH-1:0]  size  [NUM_BARRIERS];
    logic [NC_WIDTH-1:0]  ptr;

    logic [NUM_CORES-1:0] eligible;
    logic [NUM_CORES-1:0] bad_id;
    logic [NUM_CORES-1:0] grant;
    logic                 found;
    logic [NC_WIDTH-1:0]  g_core;
    logic [NB_WIDTH-1:0]  g_id;
    logic [NC_WIDTH-1:0]  g_size;
    logic                 hs;
    logic                 first;
    logic                 complete;
    logic                 mismatch;

    // A core is eligible when its ID is in range and it has not yet arrived at that barrier
    always_comb begin
        eligible = '0;
        bad_id   = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (req_valid[i]) begin
                if (32'(req_id[i*NB_WIDTH +: NB_WIDTH]) < NUM_BARRIERS) begin
                    eligible[i] = !mask[req_id[i*NB_WIDTH +: NB_WIDTH]][i];
                end else begin
                    bad_id[i] = 1'b1;
                end
            end
        end
    end

    // Round-robin pick starting at ptr
    always_comb begin
        grant  = '0;
        found  = 1'b0;
        g_core = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (!found && eligible[(32'(ptr) + 32'(k)) % NUM_CORES]) begin
                found  = 1'b1;
                grant[(32'(ptr) + 32'(k)) % NUM_CORES] = 1'b1;
                g_core = NC_WIDTH'((32'(ptr) + 32'(k)) % NUM_CORES);
            end
        end
    end

    assign req_ready = reset ? '0 : grant;
    assign hs        = found && !reset;
    assign g_id      = req_id[32'(g_core)*NB_WIDTH +: NB_WIDTH];
    assign g_size    = req_size_m1[32'(g_core)*NC_WIDTH +: NC_WIDTH];
    assign first     = (mask[g_id] == '0);
    // The first arrival brings its own size; later arrivals are judged against the latched one
    assign complete  = first ? (g_size == '0) : (count[g_id] == size[g_id]);
    assign mismatch  = !first && (g_size != size[g_id]);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < NUM_BARRIERS; b++) begin
                mask[b]  <= '0;
                count[b] <= '0;
                size[b]  <= '0;
            end
            ptr       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            err_valid <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            err_valid <= (hs && mismatch) || (|bad_id);
            if (hs) begin
                ptr <= (32'(g_core) == NUM_CORES - 1) ? '0 : g_core + NC_WIDTH'(1);
                if (complete) begin
                    mask[g_id]  <= '0;
                    count[g_id] <= '0;
                    size[g_id]  <= '0;
                    rsp_valid   <= 1'b1;
                    rsp_id      <= g_id;
                end else begin
                    mask[g_id]  <= mask[g_id] | grant;
                    count[g_id] <= count[g_id] + NC_WIDTH'(1);
                    if (first) begin
                        size[g_id] <= g_size;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_gbar_arbiter.sv
// Directed, table-driven bench for gbar_arbiter (4 cores, 4 barrier IDs): one table row per clock cycle,
// followed by a hand-written mid-operation reset sequence.
module tb_gbar_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req_valid;
    logic [7:0] req_id;
    logic [7:0] req_size_m1;
    logic [3:0] req_ready;
    logic       rsp_valid;
    logic [1:0] rsp_id;
    logic       err_valid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] valid;
        logic [7:0] id;
        logic [7:0] size;
        logic [3:0] ready;
        logic       rv;
        logic [1:0] rid;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    gbar_arbiter #(.NUM_CORES(4), .NUM_BARRIERS(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_id      (req_id),
        .req_size_m1 (req_size_m1),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .err_valid   (err_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [3:0] v, input logic [7:0] id, input logic [7:0] sz,
                       input logic [3:0] rdy, input logic rv, input logic [1:0] rid, input logic err);
        vec_t t;
        t.valid = v; t.id = id; t.size = sz; t.ready = rdy; t.rv = rv; t.rid = rid; t.err = err;
        vecs.push_back(t);
    endtask

    // Inputs change at negedge; req_ready is sampled 1ns later, registered outputs show the previous cycle
    task automatic apply(input vec_t t, input int row);
        @(negedge clk);
        req_valid   = t.valid;
        req_id      = t.id;
        req_size_m1 = t.size;
        #1;
        check($sformatf("row%0d ready", row), 32'(req_ready), 32'(t.ready));
        check($sformatf("row%0d rsp_valid", row), 32'(rsp_valid), 32'(t.rv));
        if (t.rv) check($sformatf("row%0d rsp_id", row), 32'(rsp_id), 32'(t.rid));
        check($sformatf("row%0d err", row), 32'(err_valid), 32'(t.err));
    endtask

    initial begin
        reset = 1'b1; req_valid = 4'b1111; req_id = '0; req_size_m1 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset ready", 32'(req_ready), 32'h0);
        check("reset rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset err", 32'(err_valid), 32'h0);
        @(negedge clk);
        reset = 1'b0; req_valid = '0;

        // Four cores on id1, size 4: round-robin 0,1,2,3, release after core 3
        add(4'b1111, {2'd1,2'd1,2'd1,2'd1}, {2'd3,2'd3,2'd3,2'd3}, 4'b0001, 0, 0, 0);
        add(4'b1111, {2'd1,2'd1,2'd1,2'd1}, {2'd3,2'd3,2'd3,2'd3}, 4'b0010, 0, 0, 0);
        add(4'b1111, {2'd1,2'd1,2'd1,2'd1}, {2'd3,2'd3,2'd3,2'd3}, 4'b0100, 0, 0, 0);
        add(4'b1111, {2'd1,2'd1,2'd1,2'd1}, {2'd3,2'd3,2'd3,2'd3}, 4'b1000, 0, 0, 0);
        add(4'b0000, 8'h00, 8'h00, 4'b0000, 1, 2'd1, 0);
        // Single-core barrier completes on its own arrival
        add(4'b0100, {2'd0,2'd0,2'd0,2'd0}, {2'd0,2'd0,2'd0,2'd0}, 4'b0100, 0, 0, 0);
        add(4'b0000, 8'h00, 8'h00, 4'b0000, 1, 2'd0, 0);
        // Duplicate arrival by core 1 is held until id2 releases
        add(4'b0010, {2'd0,2'd0,2'd2,2'd0}, {2'd0,2'd0,2'd2,2'd0}, 4'b0010, 0, 0, 0);
        add(4'b0010, {2'd0,2'd0,2'd2,2'd0}, {2'd0,2'd0,2'd2,2'd0}, 4'b0000, 0, 0, 0);
        add(4'b1011, {2'd2,2'd0,2'd2,2'd2}, {2'd2,2'd0,2'd2,2'd2}, 4'b1000, 0, 0, 0);
        add(4'b1011, {2'd2,2'd0,2'd2,2'd2}, {2'd2,2'd0,2'd2,2'd2}, 4'b0001, 0, 0, 0);
        add(4'b0010, {2'd0,2'd0,2'd2,2'd0}, {2'd0,2'd0,2'd2,2'd0}, 4'b0010, 1, 2'd2, 0);
        add(4'b0000, 8'h00, 8'h00, 4'b0000, 0, 0, 0);
        // Size mismatch: err pulses once, latched size 2 still governs the release
        add(4'b0001, {2'd0,2'd0,2'd0,2'd3}, {2'd0,2'd0,2'd0,2'd1}, 4'b0001, 0, 0, 0);
        add(4'b0010, {2'd0,2'd0,2'd3,2'd0}, {2'd0,2'd0,2'd2,2'd0}, 4'b0010, 0, 0, 0);
        add(4'b0000, 8'h00, 8'h00, 4'b0000, 1, 2'd3, 1);
        add(4'b0000, 8'h00, 8'h00, 4'b0000, 0, 0, 0);
        // Interleaved id0/id1 pairs release independently
        add(4'b0001, {2'd0,2'd0,2'd0,2'd0}, {2'd0,2'd0,2'd0,2'd1}, 4'b0001, 0, 0, 0);
        add(4'b0010, {2'd0,2'd0,2'd1,2'd0}, {2'd0,2'd0,2'd1,2'd0}, 4'b0010, 0, 0, 0);
        add(4'b0100, {2'd0,2'd0,2'd0,2'd0}, {2'd0,2'd1,2'd0,2'd0}, 4'b0100, 0, 0, 0);
        add(4'b1000, {2'd1,2'd0,2'd0,2'd0}, {2'd1,2'd0,2'd0,2'd0}, 4'b1000, 1, 2'd0, 0);
        add(4'b0000, 8'h00, 8'h00, 4'b0000, 1, 2'd1, 0);
        add(4'b0000, 8'h00, 8'h00, 4'b0000, 0, 0, 0);

        foreach (vecs[r]) apply(vecs[r], r);

        // Reset after 2 of 4 arrivals on id1: no release, and state and pointer start fresh
        @(negedge clk);
        req_valid = 4'b1111; req_id = {2'd1,2'd1,2'd1,2'd1}; req_size_m1 = {2'd3,2'd3,2'd3,2'd3};
        #1 check("pre-rst grant0", 32'(req_ready), 32'h1);
        @(negedge clk);
        #1 check("pre-rst grant1", 32'(req_ready), 32'h2);
        @(negedge clk);
        reset = 1'b1;
        #1 check("mid-rst ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int g = 0; g < 4; g++) begin
            #1;
            check($sformatf("post-rst grant%0d", g), 32'(req_ready), 32'(4'b0001 << g));
            check($sformatf("post-rst no rsp%0d", g), 32'(rsp_valid), 32'h0);
            @(negedge clk);
        end
        req_valid = '0;
        #1;
        check("post-rst rsp_valid", 32'(rsp_valid), 32'h1);
        check("post-rst rsp_id", 32'(rsp_id), 32'h1);
        @(negedge clk);
        #1 check("post-rst rsp one cycle", 32'(rsp_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
